// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing analyser: default counter width,
// lock FSM states and the measurement bundle handed to the debug overlay.
package video_timing_pkg;

    localparam int unsigned VT_W = 9;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CHECK,
        ST_LOCKED
    } lock_state_t;

    typedef struct packed {
        logic [VT_W-1:0] htotal;
        logic [VT_W-1:0] vtotal;
        logic [VT_W-1:0] hact;
        logic [VT_W-1:0] vact;
        logic [VT_W-1:0] hs_start;
        logic [VT_W-1:0] hs_width;
        logic [VT_W-1:0] vs_start;
        logic [VT_W-1:0] vs_width;
    } vt_meas_t;

endpackage

// File: rtl/vt_span_counter.sv
// Saturating span counter with clear and increment events; exposes the
// next-state value so the parent can capture it on the same tick.
module vt_span_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned W = VT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         sat
);

    // sat flags the increment that lands on (or stays at) the all-ones value
    always_comb begin
        nxt = cnt;
        sat = 1'b0;
        if (clr) begin
            nxt = '0;
        end else if (inc) begin
            sat = &cnt[W-1:1];
            if (!(&cnt)) begin
                nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/video_timing_meas.sv
// Passive raster analyser: recovers h/v position, measures geometry and lock.
// Define VIDEO_TIMING_MEAS_SYNC_EN to build the hs/vs placement captures.
module video_timing_meas
    import video_timing_pkg::*;
#(
    parameter int unsigned W           = VT_W,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_pix,
    input  logic         hsync,
    input  logic         vsync,
    input  logic         hbl,
    input  logic         vbl,
    output logic [W-1:0] hcnt,
    output logic [W-1:0] vcnt,
    output logic         line_start,
    output logic         frame_start,
    output logic [W-1:0] htotal,
    output logic [W-1:0] vtotal,
    output logic [W-1:0] hact,
    output logic [W-1:0] vact,
    output logic [W-1:0] hs_start,
    output logic [W-1:0] hs_width,
    output logic [W-1:0] vs_start,
    output logic [W-1:0] vs_width,
    output logic         locked
);

    localparam int unsigned    SW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [SW-1:0]  STABLE_MAX = SW'(LOCK_FRAMES);

    logic          hbl_q, vbl_q;
    logic          ls, fs, hbl_rise, vbl_rise;
    logic [W-1:0]  hn, vn, h_plus, v_plus;
    logic          h_sat, v_sat;
    logic          ls_seen, fs_seen, frame_bad;
    logic          bad_now, fs_good;
    lock_state_t   state, state_n;
    logic [SW-1:0] stable, stable_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_q <= 1'b0;
            vbl_q <= 1'b0;
        end else if (ce_pix) begin
            hbl_q <= hbl;
            vbl_q <= vbl;
        end
    end

    assign ls       = hbl_q & ~hbl;
    assign fs       = vbl_q & ~vbl;
    assign hbl_rise = ~hbl_q & hbl;
    assign vbl_rise = ~vbl_q & vbl;

    vt_span_counter #(.W(W)) u_hcount (
        .clk   (clk),
        .reset (reset),
        .tick  (ce_pix),
        .clr   (ls),
        .inc   (1'b1),
        .cnt   (hcnt),
        .nxt   (hn),
        .sat   (h_sat)
    );

    vt_span_counter #(.W(W)) u_vcount (
        .clk   (clk),
        .reset (reset),
        .tick  (ce_pix),
        .clr   (fs),
        .inc   (ls),
        .cnt   (vcnt),
        .nxt   (vn),
        .sat   (v_sat)
    );

    assign h_plus  = hcnt + 1'b1;
    assign v_plus  = vcnt + 1'b1;
    assign bad_now = (ls & (~ls_seen | (h_plus != htotal))) | h_sat | v_sat;
    assign fs_good = ~frame_bad & ~bad_now & fs_seen & (v_plus == vtotal);

    // A mid-frame fault only unlocks immediately from LOCKED; otherwise the
    // frame is judged at its closing FS via frame_bad.
    always_comb begin
        state_n  = state;
        stable_n = stable;
        if (fs) begin
            if (fs_good) begin
                if (stable != STABLE_MAX) begin
                    stable_n = stable + 1'b1;
                end
                state_n = (stable_n == STABLE_MAX) ? ST_LOCKED : ST_CHECK;
            end else begin
                stable_n = '0;
                state_n  = ST_UNLOCKED;
            end
        end else if (bad_now && (state == ST_LOCKED)) begin
            stable_n = '0;
            state_n  = ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_UNLOCKED;
            stable    <= '0;
            frame_bad <= 1'b0;
            ls_seen   <= 1'b0;
            fs_seen   <= 1'b0;
        end else if (ce_pix) begin
            state  <= state_n;
            stable <= stable_n;
            if (fs) begin
                frame_bad <= 1'b0;
            end else if (bad_now) begin
                frame_bad <= 1'b1;
            end
            if (ls) ls_seen <= 1'b1;
            if (fs) fs_seen <= 1'b1;
        end
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            htotal      <= '0;
            vtotal      <= '0;
            hact        <= '0;
            vact        <= '0;
        end else begin
            line_start  <= ce_pix & ls;
            frame_start <= ce_pix & fs;
            if (ce_pix) begin
                if (ls)       htotal <= h_plus;
                if (fs)       vtotal <= v_plus;
                if (hbl_rise) hact   <= hn;
                if (vbl_rise) vact   <= vn;
            end
        end
    end

`ifdef VIDEO_TIMING_MEAS_SYNC_EN
    logic hsync_q, vsync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hs_start <= '0;
            hs_width <= '0;
            vs_start <= '0;
            vs_width <= '0;
        end else if (ce_pix) begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            if (hsync & ~hsync_q) hs_start <= hn;
            if (~hsync & hsync_q) hs_width <= hn - hs_start;
            if (vsync & ~vsync_q) vs_start <= vn;
            if (~vsync & vsync_q) vs_width <= vn - vs_start;
        end
    end
`else
    logic unused_sync;
    assign unused_sync = hsync ^ vsync;
    assign hs_start    = '0;
    assign hs_width    = '0;
    assign vs_start    = '0;
    assign vs_width    = '0;
`endif

endmodule

// File: tb/tb_video_timing_meas.sv
// Bench for video_timing_meas: raster generator, per-tick behavioural model
// with every-cycle comparison, plus hand-computed checkpoints.
module tb_video_timing_meas;

    localparam int W    = 9;
    localparam int M    = 1 << W;
    localparam int MAXC = M - 1;
    localparam int LF   = 2;
`ifdef VIDEO_TIMING_MEAS_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, ce_pix = 1'b0;
    logic hsync = 1'b0, vsync = 1'b0, hbl = 1'b0, vbl = 1'b0;
    logic [W-1:0] hcnt, vcnt, htotal, vtotal, hact, vact;
    logic [W-1:0] hs_start, hs_width, vs_start, vs_width;
    logic line_start, frame_start, locked;

    always #5 clk = ~clk;

    video_timing_meas #(.W(W), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hsync(hsync), .vsync(vsync), .hbl(hbl), .vbl(vbl),
        .hcnt(hcnt), .vcnt(vcnt), .line_start(line_start), .frame_start(frame_start),
        .htotal(htotal), .vtotal(vtotal), .hact(hact), .vact(vact),
        .hs_start(hs_start), .hs_width(hs_width), .vs_start(vs_start), .vs_width(vs_width),
        .locked(locked)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic finish_up;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
            if (errors >= 100) finish_up();
        end
    endtask

    // ---------------- behavioural model (integers, one call per tick)
    int m_h, m_v, m_htotal, m_vtotal, m_hact, m_vact;
    int m_hss, m_hsw, m_vss, m_vsw, m_stable;
    bit m_locked, m_ls, m_fs, m_fbad, m_lsseen, m_fsseen;
    bit p_hbl, p_vbl, p_hs, p_vs;

    task automatic model_reset;
        m_h = 0; m_v = 0; m_htotal = 0; m_vtotal = 0; m_hact = 0; m_vact = 0;
        m_hss = 0; m_hsw = 0; m_vss = 0; m_vsw = 0; m_stable = 0;
        m_locked = 0; m_ls = 0; m_fs = 0; m_fbad = 0; m_lsseen = 0; m_fsseen = 0;
        p_hbl = 0; p_vbl = 0; p_hs = 0; p_vs = 0;
    endtask

    task automatic model_tick(input bit b_h, input bit b_v, input bit s_h, input bit s_v);
        bit ls, fs, hsat, vsat, bad, good;
        int hn, vn;
        ls   = p_hbl && !b_h;
        fs   = p_vbl && !b_v;
        hn   = ls ? 0 : ((m_h + 1 > MAXC) ? MAXC : m_h + 1);
        hsat = !ls && (m_h + 1 >= MAXC);
        vn   = fs ? 0 : (ls ? ((m_v + 1 > MAXC) ? MAXC : m_v + 1) : m_v);
        vsat = !fs && ls && (m_v + 1 >= MAXC);
        bad  = (ls && (!m_lsseen || ((m_h + 1) % M) != m_htotal)) || hsat || vsat;
        if (fs) begin
            good = !m_fbad && !bad && m_fsseen && (((m_v + 1) % M) == m_vtotal);
            if (good) begin
                if (m_stable < LF) m_stable++;
                if (m_stable >= LF) m_locked = 1;
            end else begin
                m_stable = 0;
                m_locked = 0;
            end
            m_fbad = 0;
        end else if (bad) begin
            m_fbad   = 1;
            m_locked = 0;
        end
        if (ls) m_htotal = (m_h + 1) % M;
        if (fs) m_vtotal = (m_v + 1) % M;
        if (!p_hbl && b_h) m_hact = hn;
        if (!p_vbl && b_v) m_vact = vn;
        if (SYNC) begin
            if (!p_hs && s_h) m_hss = hn;
            if (p_hs && !s_h) m_hsw = (hn - m_hss + M) % M;
            if (!p_vs && s_v) m_vss = vn;
            if (p_vs && !s_v) m_vsw = (vn - m_vss + M) % M;
        end
        if (ls) m_lsseen = 1;
        if (fs) m_fsseen = 1;
        m_h = hn; m_v = vn; m_ls = ls; m_fs = fs;
        p_hbl = b_h; p_vbl = b_v; p_hs = s_h; p_vs = s_v;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
            chk_en = 1'b1;
        end else begin
            m_ls = 0;
            m_fs = 0;
            if (ce_pix) model_tick(hbl, vbl, hsync, vsync);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hcnt",        32'(hcnt),        m_h);
            check("vcnt",        32'(vcnt),        m_v);
            check("line_start",  32'(line_start),  32'(m_ls));
            check("frame_start", 32'(frame_start), 32'(m_fs));
            check("htotal",      32'(htotal),      m_htotal);
            check("vtotal",      32'(vtotal),      m_vtotal);
            check("hact",        32'(hact),        m_hact);
            check("vact",        32'(vact),        m_vact);
            check("hs_start",    32'(hs_start),    m_hss);
            check("hs_width",    32'(hs_width),    m_hsw);
            check("vs_start",    32'(vs_start),    m_vss);
            check("vs_width",    32'(vs_width),    m_vsw);
            check("locked",      32'(locked),      32'(m_locked));
        end
    end

    // ---------------- raster generator
    int ce_mode;
    int g_htot, g_hbs, g_hss, g_hse, g_vtot, g_vact, g_vss, g_vse, g_long, g_extra, gx, gl;

    task automatic tick(input bit b_h, input bit b_v, input bit s_h, input bit s_v);
        int d;
        hbl = b_h; vbl = b_v; hsync = s_h; vsync = s_v;
        d = (ce_mode == 0) ? 0 : ((ce_mode == 1) ? 3 : int'($urandom_range(3, 0)));
        repeat (d) begin
            ce_pix = 1'b0;
            @(posedge clk); #1;
        end
        ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
    endtask

    task automatic set_raster(input int ht, input int hbs, input int hss, input int hse,
                              input int vt, input int va, input int vss, input int vse);
        g_htot = ht; g_hbs = hbs; g_hss = hss; g_hse = hse;
        g_vtot = vt; g_vact = va; g_vss = vss; g_vse = vse;
        g_long = -1; g_extra = 0; gx = 0; gl = 0;
    endtask

    task automatic gen(input int n);
        int len;
        repeat (n) begin
            len = g_htot + ((gl == g_long) ? g_extra : 0);
            tick(gx >= g_hbs, gl >= g_vact, (gx >= g_hss) && (gx < g_hse), (gl >= g_vss) && (gl < g_vse));
            gx++;
            if (gx >= len) begin
                gx = 0;
                if (gl == g_long) g_long = -1;
                gl++;
                if (gl >= g_vtot) gl = 0;
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ce_pix = 1'b0;
        @(posedge clk); #1;
        check("rst_hcnt", 32'(hcnt), 0);
        check("rst_vcnt", 32'(vcnt), 0);
        check("rst_htotal", 32'(htotal), 0);
        check("rst_vtotal", 32'(vtotal), 0);
        check("rst_hact", 32'(hact), 0);
        check("rst_vact", 32'(vact), 0);
        check("rst_sync", 32'({hs_start, hs_width, vs_start, vs_width}), 0);
        check("rst_pulses", 32'({line_start, frame_start}), 0);
        check("rst_locked", 32'(locked), 0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        finish_up();
    end

    initial begin
        int fa, fb;
        int ht, hbs, hss, hse, vt, va, vss, vse;

        // Large raster: full 384-tick lines, 24 lines per frame
        ce_mode = 0;
        set_raster(384, 256, 264, 296, 24, 18, 19, 21);
        fa = 384 * 24;
        do_reset();
        gen(fa);
        gen(1);
        check("s1_fs1_locked", 32'(locked), 0);
        check("s1_fs1_pulse", 32'(frame_start), 1);
        check("s1_fs1_vtotal", 32'(vtotal), 24);
        gen(fa - 1);
        gen(1);
        check("s1_fs2_locked", 32'(locked), 0);
        gen(fa - 1);
        check("s1_pre_fs3_locked", 32'(locked), 0);
        gen(1);
        check("s1_fs3_locked", 32'(locked), 1);
        check("s1_htotal", 32'(htotal), 384);
        check("s1_vtotal", 32'(vtotal), 24);
        check("s1_hact", 32'(hact), 256);
        check("s1_vact", 32'(vact), 18);
        check("s1_hs_start", 32'(hs_start), SYNC ? 264 : 0);
        check("s1_hs_width", 32'(hs_width), SYNC ? 32 : 0);
        check("s1_vs_start", 32'(vs_start), SYNC ? 19 : 0);
        check("s1_vs_width", 32'(vs_width), SYNC ? 2 : 0);

        // Small raster: one line lengthened by a tick while locked
        set_raster(48, 32, 34, 38, 12, 9, 9, 11);
        fb = 48 * 12;
        do_reset();
        gen(3 * fb + 1);
        check("s2_locked", 32'(locked), 1);
        g_long = 4;
        g_extra = 1;
        gen(4 * 48 - 1 + 49);
        check("s2_pre_long_locked", 32'(locked), 1);
        gen(1);
        check("s2_long_drop", 32'(locked), 0);
        check("s2_long_htotal", 32'(htotal), 49);
        gen((12 - 5) * 48 - 1);
        gen(1);
        check("s2_bad_fs_locked", 32'(locked), 0);
        gen(fb - 1);
        gen(1);
        check("s2_relock_fs1", 32'(locked), 0);
        gen(fb - 1);
        gen(1);
        check("s2_relock_fs2", 32'(locked), 1);

        // hbl stuck low: horizontal counter saturates and lock drops there
        repeat (510) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_hcnt_510", 32'(hcnt), 510);
        check("s3_locked_510", 32'(locked), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_hcnt_511", 32'(hcnt), 511);
        check("s3_sat_drop", 32'(locked), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_hcnt_hold", 32'(hcnt), 511);

        // Same small raster with a 1-in-4 pixel enable
        ce_mode = 1;
        set_raster(48, 32, 34, 38, 12, 9, 9, 11);
        do_reset();
        gen(3 * fb + 1);
        check("s4_locked", 32'(locked), 1);
        check("s4_htotal", 32'(htotal), 48);
        check("s4_vtotal", 32'(vtotal), 12);
        check("s4_hact", 32'(hact), 32);
        check("s4_vact", 32'(vact), 9);
        check("s4_hs_start", 32'(hs_start), SYNC ? 34 : 0);
        check("s4_hs_width", 32'(hs_width), SYNC ? 4 : 0);
        check("s4_vs_start", 32'(vs_start), SYNC ? 9 : 0);
        check("s4_vs_width", 32'(vs_width), SYNC ? 2 : 0);
        check("s4_ls_high", 32'(line_start), 1);
        @(posedge clk); #1;
        check("s4_ls_one_clk", 32'(line_start), 0);
        check("s4_fs_one_clk", 32'(frame_start), 0);

        // Random enable, reset pulsed mid-frame, then continue the raster
        ce_mode = 2;
        gen(fb + int'($urandom_range(fb - 1, 0)));
        do_reset();
        gen(3 * fb);

        // Random geometries with occasional lengthened lines
        repeat (2) begin
            ht  = int'($urandom_range(60, 24));
            hbs = int'($urandom_range(ht - 2, ht / 2));
            hss = int'($urandom_range(ht - 3, 1));
            hse = int'($urandom_range(ht - 1, hss + 1));
            vt  = int'($urandom_range(10, 6));
            va  = int'($urandom_range(vt - 2, 3));
            vss = int'($urandom_range(vt - 3, 1));
            vse = int'($urandom_range(vt - 1, vss + 1));
            set_raster(ht, hbs, hss, hse, vt, va, vss, vse);
            do_reset();
            for (int f = 0; f < 5; f++) begin
                if ($urandom_range(2, 0) == 0) begin
                    g_long  = int'($urandom_range(vt - 1, 1));
                    g_extra = int'($urandom_range(3, 1));
                end
                gen(ht * vt);
            end
        end

        @(posedge clk); #1;
        finish_up();
    end

endmodule

// File: doc/video_timing_meas.md
# video_timing_meas

Passive raster analyser that consumes the active-high sync/blank outputs of the core's video timing generator, or any equivalent source, on the pixel clock-enable. It recovers the pixel and line position and measures line length, frame height, active area and sync placement. It asserts `locked` once the raster is stable. It sits on the video path ahead of the scan-doubler/OSD and drives the debug overlay and the hs/vs offset calibration logic.

## Interface
- `W`, default 9: width of all counters and measurement outputs.
- `LOCK_FRAMES`, default 2: number of consecutive identical frames required before `locked` asserts.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high. Clock is `clk`.
- `ce_pix`  in  1  pixel enable. All logic advances only on a "tick", meaning `clk` with `ce_pix=1`.
- `hsync`, `vsync`, `hbl`, `vbl`  in  1 each  active-high raster inputs.
- `hcnt`, `vcnt`  out  W  recovered position registers.
- `line_start`, `frame_start`  out  1  one-`clk` registered event pulses.
- `htotal`, `vtotal`  out  W  ticks per line, lines per frame.
- `hact`, `vact`  out  W  active pixels and active lines.
- `hs_start`, `hs_width`, `vs_start`, `vs_width`  out  W  sync placement.
- `locked`  out  1  raster stable.

## Operation
- Inputs are registered on every tick. An edge is detected by comparing the input with its previous tick's value.
- Line start (LS): falling edge of `hbl`. Frame start (FS): falling edge of `vbl`.
- Horizontal counter, next-state value `hn`:
  - `hn = 0` on LS; otherwise `hn = hcnt+1`.
  - Saturates at 2^W−1.
- Vertical counter, next-state value `vn`:
  - `vn = 0` on FS (FS wins over a coincident LS).
  - `vn = vcnt+1` on LS.
  - Otherwise `vn = vcnt`.
  - Saturates at 2^W−1.
- Captures (all use the same tick's next-state value):
  - On LS: `htotal <= hcnt+1`. On FS: `vtotal <= vcnt+1`.
  - On `hbl` rise: `hact <= hn`. On `vbl` rise: `vact <= vn`.
  - On `hsync` rise: `hs_start <= hn`. On `hsync` fall: `hs_width <= hn − hs_start` (mod 2^W).
  - On `vsync` rise: `vs_start <= vn`. On `vsync` fall: `vs_width <= vn − vs_start` (mod 2^W).
- The first LS after reset loads `htotal` from a partial line. It is captured but flagged as a mismatch. The same applies to `vtotal` on the first FS.
- Lock FSM states: UNLOCKED, CHECK, LOCKED.
  - `frame_bad` is set by any of: an LS whose `hcnt+1` differs from the `htotal` held before that tick; the first LS after reset; saturation of either counter.
  - At each FS, the frame is good if `frame_bad=0` and the new `vtotal` equals the held `vtotal`. `frame_bad` clears at each FS.
  - A good FS increments `stable` (saturating). A bad FS clears `stable` and goes to UNLOCKED.
  - The FSM enters LOCKED when `stable` reaches LOCK_FRAMES.
  - In LOCKED, any event that sets `frame_bad` drops `locked` on that same tick and moves to UNLOCKED, without waiting for FS.
- Reset mid-frame clears everything. Measurement restarts from the next LS/FS.

## Timing
- Reset value of every output is 0. The FSM resets to UNLOCKED. Edge-history registers reset to 0, so an input held high at reset release produces no falling edge until it has first gone low.
- Outputs update one `clk` after the tick that causes them.
- `line_start` and `frame_start` are high for exactly one `clk`, following the LS/FS tick.
- Between ticks all outputs hold.
- `ce_pix` held low freezes the block. This does not count as loss of sync.
- Loss of `hbl` edges: `hcnt` saturates after 2^W−1 ticks and `locked` drops on that tick.

## Configuration
- `VIDEO_TIMING_MEAS_SYNC_EN` defined: the sync capture logic for `hs_start`, `hs_width`, `vs_start` and `vs_width` is built.
- Not defined: those four outputs are tied to 0, the `hsync`/`vsync` registers are removed, and the ports remain.
- Lock and blank measurement are identical in both builds.

## Structure
- Shared package `video_timing_pkg`:
  - default `W`
  - lock FSM state enum
  - a measurement struct bundling the totals, active and sync fields, for the overlay.
- One sub-module, `vt_span_counter`: a saturating counter with reset event, increment event and "next value" output. It is instantiated once for h and once for v, with the captures done in the parent.

## Test plan
- Generator raster: 384 ticks/line, `hbl` high at offsets 256..383, 289 lines, `vbl` active offset 0..223, hs at 264..295, vs lines 228..231. After 3 frames, expected outputs:
  - `htotal=384`, `vtotal=289`, `hact=256`, `vact=224`
  - `hs_start=264`, `hs_width=32`, `vs_start=228`, `vs_width=4`
  - `locked=1`.
- Lock timing with the same raster: `locked` stays 0 after the first FS and rises one `clk` after the 3rd FS following reset. The 1st FS is a mismatch; the 2nd and 3rd are good.
- Single line lengthened to 385 ticks while locked: `locked` drops on that line's LS. It relocks after 2 further good frames.
- `hbl` stuck low: `hcnt` reaches 511 and saturates, and `locked` drops at the saturation tick.
- `ce_pix` toggling 1-in-4: results match the ce-every-cycle run. `line_start` is one `clk` wide.
- Reset pulsed mid-frame: all outputs are 0 the next `clk`. With the macro undefined, the sync outputs stay 0 throughout the first scenario.
